wb_burst_initiator: RTL and testbench
=====================================

Name: wb_burst_initiator

Overview:
- Wishbone B4 initiator (bus master) that turns a command stream into classic and incrementing-burst cycles on a 32-bit, word-addressed Wishbone bus.
- It is the initiator end of the bus that the on-chip memory and peripheral responders implement.
- Sits between a command source (loader, DMA sequencer, debug bridge) and the SoC interconnect.
- Handles write data and read responses as valid/ready streams, and bounds every bus beat with a timeout.

Parameters:
- TIMEOUT, 1024: cycles a beat may wait for ack/err while stb is high before abort; range 2..65535.
- MAX_LEN_W, 4: width of cmd_len; a burst carries up to 2^MAX_LEN_W beats.

Ports:
- sys_clk  in  1  single clock; all logic rising-edge.
- sys_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_adr  in  30  start word address.
- cmd_we  in  1  1=write, 0=read.
- cmd_sel  in  4  byte lanes, applied to every beat.
- cmd_len  in  MAX_LEN_W  beats minus one.
- wdat_valid  in  1  write beat offered.
- wdat_ready  out  1  write beat accepted.
- wdat_data  in  32  write beat data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  read data; 0 for write responses.
- rsp_err  out  1  bus error or timeout.
- rsp_last  out  1  final response of the command.
- m_bus_adr  out  30  Wishbone address.
- m_bus_dat_w  out  32  write data.
- m_bus_dat_r  in  32  read data.
- m_bus_sel  out  4  byte select.
- m_bus_cyc  out  1  cycle.
- m_bus_stb  out  1  strobe.
- m_bus_we  out  1  write enable.
- m_bus_cti  out  3  cycle type identifier.
- m_bus_bte  out  2  burst type; constant 2'b00 (linear).
- m_bus_ack  in  1  beat acknowledge.
- m_bus_err  in  1  beat error.

Behaviour:
- Reset: every output is 0 except cmd_ready; state is IDLE and all counters clear. Reset mid-cycle drops cyc/stb the next edge, discards any pending response and does not complete the command.
- All bus outputs and rsp_* outputs are registered.
- Beat completion: a beat completes on a cycle where cyc&stb&(ack|err). The next beat's adr, dat_w and cti appear on the following cycle, so no beat completes in two consecutive cycles from the same strobe. Responders that toggle ack on alternate cycles must see exactly one completion per beat.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command into beat counter, address, sel, we and len; go to BUS. cyc rises the cycle after acceptance.
  - BUS: cyc=1. stb=1 only while the beat may issue. A write beat may issue when a wdat word is held. A read beat may issue when the response register is empty or is being popped this cycle. While stb=0, cyc stays 1.
    - wdat_ready=1 only when no write word is held.
    - cti: single-beat command is 3'b000. Multi-beat command is 3'b010 on every beat except the last, which is 3'b111.
    - Address increments by 1 per completed beat, modulo 2^30.
  - DRAIN: cyc=stb=0. Accept and discard remaining wdat beats of an aborted write. Go to IDLE once the response is also delivered.
- Responses:
  - Read: one response per beat, carrying dat_r captured on ack; rsp_last set on the final beat.
  - Write: a single response after the final beat, with rsp_err = OR of all beat errors (always 0 unless aborted).
  - rsp_valid holds until rsp_ready.
  - The command ends, and the next command may be accepted, only after the last response has been accepted.
- Abort:
  - Triggers: m_bus_err on a beat, or the timeout counter reaching TIMEOUT.
  - Timeout counter: counts cycles with stb=1 and no ack/err; cleared on every completion and on stb=0.
  - Effect: cyc/stb drop the next cycle, and a response with rsp_err=1, rsp_last=1 is issued. For a timeout read, rsp_data=0.
  - Writes go to DRAIN if beats remain; reads return to IDLE after the response.
- Simultaneous ack and err on the same cycle counts as err.
- Ack arriving while stb=0 is ignored.
- The timeout counter is TIMEOUT-wide saturating, with no wrap.

Decomposition:
- Shared package wb_pkg:
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - BTE_LINEAR=2'b00.
  - State enum {IDLE, BUS, DRAIN}.
  - Response struct {data, err, last}.
- One sub-module, wb_beat_timer: saturating counter with clear, enable and expired outputs. Everything else stays in the top.

Test Plan:
- Single write: cmd adr=0x10, we=1, sel=4'hF, len=0, wdat=0xDEADBEEF against a memory responder. Required: one beat with cti=000 and adr=0x10; then one response with err=0 and last=1. A read-back command returns 0xDEADBEEF.
- Burst read: preload words 0x20..0x23 with 1..4; cmd len=3. Required: cti sequence 010,010,010,111; addresses 0x20..0x23; responses 1,2,3,4 with last only on 4. The alternating-ack responder yields exactly 4 completions.
- Backpressure: burst read len=7 with rsp_ready low for 5 cycles after the first response. Required: stb low while the slot is full; cyc stays 1; no data lost or duplicated; 8 responses in order.
- Write stall: burst write len=3 with wdat gaps of 3 cycles. Required: stb low during each gap; 4 beats written; one response with err=0.
- Error abort: write len=3 where the responder raises err on beat 2. Required: cyc drops the next cycle; response err=1, last=1; the remaining wdat beats are drained; the next command is accepted normally.
- Timeout and reset: TIMEOUT=16 with a silent responder on a read. Required: err response exactly 16 cycles after stb rose. Separately, assert sys_rst mid-burst: all outputs 0 the next cycle and cmd_ready=1 afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 types and constants for the burst initiator.
package wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {IDLE, BUS, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  function automatic logic [2:0] cti_for(input logic multi, input logic last);
    if (!multi)    return CTI_CLASSIC;
    else if (last) return CTI_EOB;
    else           return CTI_INCR;
  endfunction
endpackage

// File: rtl/wb_beat_timer.sv
// Saturating per-beat wait counter; expired fires on the cycle the count reaches TIMEOUT.
module wb_beat_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [15:0] LIM = 16'(TIMEOUT - 1);
  localparam logic [15:0] SAT = 16'(TIMEOUT);

  logic [15:0] cnt;

  assign expired = en && (cnt >= LIM);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr)          cnt <= '0;
    else if (en && cnt != SAT)   cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/wb_burst_initiator.sv
// Wishbone B4 initiator: turns commands into classic/incrementing bursts with
// valid/ready write-data and response streams and a per-beat timeout.
module wb_burst_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter int MAX_LEN_W = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [29:0]          cmd_adr,
  input  logic                 cmd_we,
  input  logic [3:0]           cmd_sel,
  input  logic [MAX_LEN_W-1:0] cmd_len,
  input  logic                 wdat_valid,
  output logic                 wdat_ready,
  input  logic [31:0]          wdat_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 rsp_last,
  output logic [29:0]          m_bus_adr,
  output logic [31:0]          m_bus_dat_w,
  input  logic [31:0]          m_bus_dat_r,
  output logic [3:0]           m_bus_sel,
  output logic                 m_bus_cyc,
  output logic                 m_bus_stb,
  output logic                 m_bus_we,
  output logic [2:0]           m_bus_cti,
  output logic [1:0]           m_bus_bte,
  input  logic                 m_bus_ack,
  input  logic                 m_bus_err
);
  localparam logic [MAX_LEN_W-1:0] REM_ONE = 1;
  localparam logic [MAX_LEN_W:0]   WD_ONE  = 1;

  state_e               state;
  logic [MAX_LEN_W-1:0] rem;      // beats left after the current one
  logic [MAX_LEN_W:0]   wd_left;  // write words not yet taken from the stream
  logic                 multi;
  rsp_t                 rsp;
  logic                 done, tmo, wd_hs, rsp_pop;

  assign done    = m_bus_cyc & m_bus_stb & (m_bus_ack | m_bus_err);
  assign rsp_pop = rsp_valid & rsp_ready;
  assign wd_hs   = wdat_valid & wdat_ready;

  assign cmd_ready  = (state == IDLE);
  // m_bus_stb doubles as the "write word held" flag while in BUS
  assign wdat_ready = (state == BUS && m_bus_we && !m_bus_stb && wd_left != '0) ||
                      (state == DRAIN && wd_left != '0);
  assign m_bus_bte  = BTE_LINEAR;
  assign rsp_data   = rsp.data;
  assign rsp_err    = rsp.err;
  assign rsp_last   = rsp.last;

  wb_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (!m_bus_stb || done),
    .en      (m_bus_cyc && m_bus_stb && !(m_bus_ack || m_bus_err)),
    .expired (tmo)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      rem         <= '0;
      wd_left     <= '0;
      multi       <= 1'b0;
      rsp         <= '0;
      rsp_valid   <= 1'b0;
      m_bus_adr   <= '0;
      m_bus_dat_w <= '0;
      m_bus_sel   <= '0;
      m_bus_cyc   <= 1'b0;
      m_bus_stb   <= 1'b0;
      m_bus_we    <= 1'b0;
      m_bus_cti   <= CTI_CLASSIC;
    end else begin
      if (rsp_pop) rsp_valid <= 1'b0;
      if (wd_hs)   wd_left   <= wd_left - WD_ONE;
      unique case (state)
        IDLE: if (cmd_valid) begin
          state     <= BUS;
          m_bus_cyc <= 1'b1;
          m_bus_stb <= !cmd_we;  // response slot is always empty here
          m_bus_adr <= cmd_adr;
          m_bus_sel <= cmd_sel;
          m_bus_we  <= cmd_we;
          rem       <= cmd_len;
          multi     <= (cmd_len != '0);
          m_bus_cti <= cti_for(cmd_len != '0, cmd_len == '0);
          wd_left   <= cmd_we ? ({1'b0, cmd_len} + WD_ONE) : '0;
        end
        BUS: begin
          if ((done && m_bus_err) || tmo) begin
            m_bus_cyc <= 1'b0;
            m_bus_stb <= 1'b0;
            state     <= DRAIN;
            rsp_valid <= 1'b1;
            rsp       <= '{data: 32'd0, err: 1'b1, last: 1'b1};
          end else if (done) begin
            m_bus_stb <= 1'b0;
            if (!m_bus_we) begin
              rsp_valid <= 1'b1;
              rsp       <= '{data: m_bus_dat_r, err: 1'b0, last: (rem == '0)};
            end else if (rem == '0) begin
              rsp_valid <= 1'b1;
              rsp       <= '{data: 32'd0, err: 1'b0, last: 1'b1};
            end
            if (rem == '0) begin
              m_bus_cyc <= 1'b0;
              state     <= DRAIN;
            end else begin
              rem       <= rem - REM_ONE;
              m_bus_adr <= m_bus_adr + 30'd1;
              m_bus_cti <= cti_for(multi, rem == REM_ONE);
            end
          end else if (m_bus_we) begin
            if (wd_hs) begin
              m_bus_dat_w <= wdat_data;
              m_bus_stb   <= 1'b1;
            end
          end else begin
            // a read beat may only be outstanding while the response slot is free
            m_bus_stb <= !rsp_valid || rsp_pop;
          end
        end
        DRAIN: if (wd_left == '0 && (!rsp_valid || rsp_pop)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_burst_initiator.sv
// Directed bench for wb_burst_initiator with a small memory responder model.
module tb_wb_burst_initiator;
  logic        sys_clk, sys_rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [29:0] cmd_adr;
  logic [3:0]  cmd_sel, cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat_data;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
  logic [31:0] rsp_data;
  logic [29:0] m_bus_adr;
  logic [31:0] m_bus_dat_w, m_bus_dat_r;
  logic [3:0]  m_bus_sel;
  logic        m_bus_cyc, m_bus_stb, m_bus_we, m_bus_ack, m_bus_err;
  logic [2:0]  m_bus_cti;
  logic [1:0]  m_bus_bte;

  wb_burst_initiator #(.TIMEOUT(16), .MAX_LEN_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .m_bus_adr(m_bus_adr), .m_bus_dat_w(m_bus_dat_w), .m_bus_dat_r(m_bus_dat_r),
    .m_bus_sel(m_bus_sel), .m_bus_cyc(m_bus_cyc), .m_bus_stb(m_bus_stb), .m_bus_we(m_bus_we),
    .m_bus_cti(m_bus_cti), .m_bus_bte(m_bus_bte), .m_bus_ack(m_bus_ack), .m_bus_err(m_bus_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {logic [29:0] adr; logic [2:0] cti; logic we; logic [31:0] dat;} beat_t;
  typedef struct packed {logic [31:0] data; logic err; logic last;} rs_t;

  int          checks, errors;
  logic [31:0] mem [0:255];
  logic        tog, ack_en, alt, err_en;
  int          err_beat, bcnt, stb_viol, stb_hi;
  beat_t       beats[$];
  rs_t         rq[$];
  logic        done;

  assign done        = m_bus_cyc & m_bus_stb & (m_bus_ack | m_bus_err);
  assign m_bus_ack   = m_bus_cyc & m_bus_stb & ack_en & (!alt | tog);
  assign m_bus_err   = m_bus_cyc & m_bus_stb & err_en & (bcnt == err_beat);
  assign m_bus_dat_r = mem[m_bus_adr[7:0]];

  // responder memory, beat/response logs and protocol monitors
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      tog      <= 1'b0;
      bcnt     <= 0;
      stb_viol <= 0;
      stb_hi   <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0FFEE00 | i;
    end else begin
      tog  <= ~tog;
      bcnt <= !m_bus_cyc ? 0 : bcnt + (done ? 1 : 0);
      if (done && !m_bus_err && m_bus_we) mem[m_bus_adr[7:0]] <= m_bus_dat_w;
      if (done) beats.push_back(beat_t'({m_bus_adr, m_bus_cti, m_bus_we, m_bus_dat_w}));
      if (rsp_valid && rsp_ready) rq.push_back(rs_t'({rsp_data, rsp_err, rsp_last}));
      if (m_bus_cyc && m_bus_stb && !m_bus_we && rsp_valid) stb_viol <= stb_viol + 1;
      if (m_bus_cyc && m_bus_stb) stb_hi <= stb_hi + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [29:0] a, input logic we, input logic [3:0] len);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_adr = a; cmd_we = we; cmd_sel = 4'hF; cmd_len = len;
    while (!cmd_ready && t < 500) begin @(negedge sys_clk); t++; end
    chk("cmd_accept", 32'(t < 500), 1);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic words(input logic [31:0] base, input int n, input int gap);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      wdat_valid = 1'b1; wdat_data = base + 32'(i);
      while (!wdat_ready && t < 500) begin @(negedge sys_clk); t++; end
      chk("wdat_accept", 32'(t < 500), 1);
      @(negedge sys_clk);
      wdat_valid = 1'b0;
      repeat (gap) @(negedge sys_clk);
    end
  endtask

  task automatic wait_rsp(input string tag, input int n);
    int t;
    t = 0;
    while (rq.size() < n && t < 500) begin @(negedge sys_clk); t++; end
    chk(tag, 32'(rq.size() >= n), 1);
  endtask

  initial begin
    int b0, r0, t, k, cyc_low, h0;
    checks = 0; errors = 0;
    cmd_valid = 0; cmd_adr = '0; cmd_we = 0; cmd_sel = '0; cmd_len = '0;
    wdat_valid = 0; wdat_data = '0; rsp_ready = 1;
    ack_en = 1; alt = 0; err_en = 0; err_beat = 0;
    sys_rst = 1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 0;
    @(negedge sys_clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_cyc_stb", 32'({m_bus_cyc, m_bus_stb, m_bus_we}), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_wdat_ready", 32'(wdat_ready), 0);
    chk("rst_bte", 32'(m_bus_bte), 0);

    // single write then read-back
    b0 = beats.size(); r0 = rq.size();
    fork
      cmd(30'h10, 1'b1, 4'd0);
      words(32'hDEADBEEF, 1, 0);
    join
    wait_rsp("wr1_rsp", r0 + 1);
    chk("wr1_nbeats", 32'(beats.size() - b0), 1);
    chk("wr1_adr", 32'(beats[b0].adr), 32'h10);
    chk("wr1_cti", 32'(beats[b0].cti), 32'b000);
    chk("wr1_we", 32'(beats[b0].we), 1);
    chk("wr1_rsp_err_last", 32'({rq[r0].err, rq[r0].last}), 32'b01);
    chk("wr1_rsp_data", rq[r0].data, 0);
    r0 = rq.size();
    cmd(30'h10, 1'b0, 4'd0);
    wait_rsp("rd1_rsp", r0 + 1);
    chk("rd1_data", rq[r0].data, 32'hDEADBEEF);
    chk("rd1_last", 32'(rq[r0].last), 1);

    // write with 3-cycle gaps between words; fills 0x20..0x23 with 1..4
    b0 = beats.size(); r0 = rq.size(); h0 = stb_hi;
    fork
      cmd(30'h20, 1'b1, 4'd3);
      words(32'd1, 4, 3);
    join
    wait_rsp("wst_rsp", r0 + 1);
    repeat (4) @(negedge sys_clk);
    chk("wst_nbeats", 32'(beats.size() - b0), 4);
    chk("wst_stb_cycles", 32'(stb_hi - h0), 4);
    chk("wst_nrsp", 32'(rq.size() - r0), 1);
    chk("wst_rsp_err", 32'(rq[r0].err), 0);
    for (int i = 0; i < 4; i++) chk("wst_dat", beats[b0 + i].dat, 32'(i + 1));

    // burst read against alternating acks
    alt = 1;
    b0 = beats.size(); r0 = rq.size();
    cmd(30'h20, 1'b0, 4'd3);
    wait_rsp("brd_rsp", r0 + 4);
    repeat (4) @(negedge sys_clk);
    chk("brd_nbeats", 32'(beats.size() - b0), 4);
    for (int i = 0; i < 4; i++) begin
      chk("brd_adr", 32'(beats[b0 + i].adr), 32'h20 + 32'(i));
      chk("brd_cti", 32'(beats[b0 + i].cti), (i == 3) ? 32'b111 : 32'b010);
      chk("brd_data", rq[r0 + i].data, 32'(i + 1));
      chk("brd_last", 32'(rq[r0 + i].last), 32'(i == 3));
    end

    // response backpressure on an 8-beat read
    b0 = beats.size(); r0 = rq.size();
    cmd(30'h20, 1'b0, 4'd7);
    t = 0;
    while (rq.size() < r0 + 1 && t < 500) begin @(negedge sys_clk); t++; end
    chk("bp_first_rsp", 32'(t < 500), 1);
    rsp_ready = 0;
    cyc_low = 0;
    repeat (5) begin @(negedge sys_clk); if (!m_bus_cyc) cyc_low++; end
    chk("bp_cyc_held", 32'(cyc_low), 0);
    chk("bp_stb_low", 32'(m_bus_stb), 0);
    chk("bp_slot_full", 32'(rsp_valid), 1);
    rsp_ready = 1;
    wait_rsp("bp_rsp", r0 + 8);
    repeat (4) @(negedge sys_clk);
    chk("bp_nbeats", 32'(beats.size() - b0), 8);
    chk("bp_nrsp", 32'(rq.size() - r0), 8);
    for (int i = 0; i < 8; i++)
      chk("bp_data", rq[r0 + i].data, (i < 4) ? 32'(i + 1) : (32'hC0FFEE20 + 32'(i)));
    chk("bp_stb_while_full", 32'(stb_viol), 0);

    // error on the second beat of a 4-beat write (ack also high: err wins)
    alt = 0; err_en = 1; err_beat = 1;
    r0 = rq.size();
    fork
      cmd(30'h30, 1'b1, 4'd3);
      words(32'hA0, 4, 0);
      begin
        t = 0;
        while (!(m_bus_cyc && m_bus_stb && m_bus_err) && t < 500) begin @(negedge sys_clk); t++; end
        chk("err_seen", 32'(t < 500), 1);
        @(negedge sys_clk);
        chk("err_cyc_drop", 32'({m_bus_cyc, m_bus_stb}), 0);
      end
    join
    wait_rsp("err_rsp", r0 + 1);
    chk("err_rsp_err_last", 32'({rq[r0].err, rq[r0].last}), 32'b11);
    err_en = 0;
    r0 = rq.size();
    cmd(30'h30, 1'b0, 4'd1);
    wait_rsp("err_next_rsp", r0 + 2);
    chk("err_beat0_written", rq[r0].data, 32'hA0);
    chk("err_beat1_dropped", rq[r0 + 1].data, 32'hC0FFEE31);

    // timeout against a silent responder
    ack_en = 0;
    r0 = rq.size();
    cmd(30'h40, 1'b0, 4'd0);
    t = 0;
    while (!m_bus_stb && t < 100) begin @(negedge sys_clk); t++; end
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge sys_clk); k++; end
    chk("tmo_latency", 32'(k), 16);
    chk("tmo_err_last", 32'({rsp_err, rsp_last}), 32'b11);
    chk("tmo_data", rsp_data, 0);
    chk("tmo_cyc", 32'(m_bus_cyc), 0);
    ack_en = 1;
    wait_rsp("tmo_pop", r0 + 1);
    repeat (3) @(negedge sys_clk);
    chk("tmo_back_idle", 32'(cmd_ready), 1);

    // reset in the middle of a burst
    alt = 1;
    r0 = rq.size();
    cmd(30'h20, 1'b0, 4'd7);
    t = 0;
    while (rq.size() < r0 + 2 && t < 500) begin @(negedge sys_clk); t++; end
    chk("mid_rst_progress", 32'(t < 500), 1);
    sys_rst = 1;
    @(negedge sys_clk);
    chk("mid_rst_bus", 32'({m_bus_cyc, m_bus_stb, m_bus_we, m_bus_cti}), 0);
    chk("mid_rst_adr", 32'(m_bus_adr), 0);
    chk("mid_rst_rsp", 32'({rsp_valid, rsp_err, rsp_last, wdat_ready}), 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    sys_rst = 0;
    @(negedge sys_clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    r0 = rq.size();
    cmd(30'h20, 1'b0, 4'd0);
    wait_rsp("post_rst_rsp", r0 + 1);
    chk("post_rst_data", rq[r0].data, 32'hC0FFEE20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
